// File: rtl/adder_resp_checker.sv
// adder_resp_checker
// Response-side checker for an adder under test. Takes operand vectors over a
// valid/ready handshake, holds them on dut_a/dut_b for SETTLE_CYCLES, then
// compares dut_sum against a full-width golden a+b. It keeps saturating
// pass/error counters, a sticky error flag and a copy of the first failing vector.
//
// Handshake: a vector transfers on a rising clk edge where vec_valid && vec_ready.
// vec_ready is high only in IDLE. The vec_* inputs are ignored at every other edge.
module adder_resp_checker #(
   parameter int WIDTH         = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             vec_valid,
   output logic             vec_ready,
   input  logic [WIDTH-1:0] vec_a,
   input  logic [WIDTH-1:0] vec_b,
   output logic [WIDTH-1:0] dut_a,
   output logic [WIDTH-1:0] dut_b,
   input  logic [WIDTH:0]   dut_sum,
   output logic             busy,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err_flag,
   output logic [WIDTH-1:0] first_err_a,
   output logic [WIDTH-1:0] first_err_b,
   output logic [WIDTH:0]   first_err_sum
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_CHECK  = 2'd2;

   // The settle counter only needs to hold SETTLE_CYCLES-1.
   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [1:0]       state_q,    state_d;
   logic [SC_W-1:0]  settle_q,   settle_d;
   logic [WIDTH-1:0] dut_a_q,    dut_a_d;
   logic [WIDTH-1:0] dut_b_q,    dut_b_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;
   logic             err_flag_q, err_flag_d;
   logic [WIDTH-1:0] fe_a_q,     fe_a_d;
   logic [WIDTH-1:0] fe_b_q,     fe_b_d;
   logic [WIDTH:0]   fe_sum_q,   fe_sum_d;
   logic [WIDTH:0]   golden_sum;

   // Golden sum is computed one bit wider than the operands so the carry is kept.
   always_comb begin
      golden_sum = {1'b0, dut_a_q} + {1'b0, dut_b_q};
   end

   // Sequencing: accept in IDLE, hold operands through SETTLE, compare once in CHECK.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      dut_a_d  = dut_a_q;
      dut_b_d  = dut_b_q;
      case (state_q)
         ST_IDLE: begin
            if (vec_valid) begin
               dut_a_d  = vec_a;
               dut_b_d  = vec_b;
               settle_d = SC_LOAD;
               state_d  = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (settle_q == '0) begin
               state_d = ST_CHECK;
            end else begin
               settle_d = settle_q - SC_W'(1);
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Statistics: clr beats a simultaneous compare, so that result is dropped.
   always_comb begin
      pass_cnt_d = pass_cnt_q;
      err_cnt_d  = err_cnt_q;
      err_flag_d = err_flag_q;
      fe_a_d     = fe_a_q;
      fe_b_d     = fe_b_q;
      fe_sum_d   = fe_sum_q;
      if (clr) begin
         pass_cnt_d = '0;
         err_cnt_d  = '0;
         err_flag_d = 1'b0;
         fe_a_d     = '0;
         fe_b_d     = '0;
         fe_sum_d   = '0;
      end else if (state_q == ST_CHECK) begin
         if (dut_sum == golden_sum) begin
            if (pass_cnt_q != CNT_MAX) begin
               pass_cnt_d = pass_cnt_q + CNT_W'(1);
            end
         end else begin
            if (err_cnt_q != CNT_MAX) begin
               err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            err_flag_d = 1'b1;
            if (!err_flag_q) begin
               fe_a_d   = dut_a_q;
               fe_b_d   = dut_b_q;
               fe_sum_d = dut_sum;
            end
         end
      end
   end

   // State and data registers; reset aborts any vector in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         settle_q   <= '0;
         dut_a_q    <= '0;
         dut_b_q    <= '0;
         pass_cnt_q <= '0;
         err_cnt_q  <= '0;
         err_flag_q <= 1'b0;
         fe_a_q     <= '0;
         fe_b_q     <= '0;
         fe_sum_q   <= '0;
      end else begin
         state_q    <= state_d;
         settle_q   <= settle_d;
         dut_a_q    <= dut_a_d;
         dut_b_q    <= dut_b_d;
         pass_cnt_q <= pass_cnt_d;
         err_cnt_q  <= err_cnt_d;
         err_flag_q <= err_flag_d;
         fe_a_q     <= fe_a_d;
         fe_b_q     <= fe_b_d;
         fe_sum_q   <= fe_sum_d;
      end
   end

   assign vec_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign dut_a         = dut_a_q;
   assign dut_b         = dut_b_q;
   assign pass_cnt      = pass_cnt_q;
   assign err_cnt       = err_cnt_q;
   assign err_flag      = err_flag_q;
   assign first_err_a   = fe_a_q;
   assign first_err_b   = fe_b_q;
   assign first_err_sum = fe_sum_q;

endmodule

// File: tb/tb_adder_resp_checker.sv
// Bench for adder_resp_checker. Two instances share the stimulus: one with
// 16-bit counters and one with 2-bit counters so that saturation is exercised.
// The adder under test is modelled here, with an optional stuck-at-0 fault on sum[2].
module tb_adder_resp_checker;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       clr;
   logic       vec_valid;
   logic [1:0] vec_a, vec_b;
   logic       fault;

   logic        vec_ready, busy, err_flag;
   logic [1:0]  dut_a, dut_b, fe_a, fe_b;
   logic [2:0]  dut_sum, fe_sum, raw_sum;
   logic [15:0] pass_cnt, err_cnt;

   logic        vec_ready2, busy2, err_flag2;
   logic [1:0]  dut_a2, dut_b2, fe_a2, fe_b2;
   logic [2:0]  dut_sum2, fe_sum2, raw_sum2;
   logic [1:0]  pass_cnt2, err_cnt2;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state, kept as plain integers.
   int m_pass, m_err, m_fa, m_fb, m_fs, m_last_a, m_last_b;
   bit m_flag;

   always #5 clk = ~clk;

   // Adder under test: correct sum, or with bit 2 forced low when fault is set.
   assign raw_sum  = {1'b0, dut_a}  + {1'b0, dut_b};
   assign raw_sum2 = {1'b0, dut_a2} + {1'b0, dut_b2};
   assign dut_sum  = fault ? {1'b0, raw_sum[1:0]}  : raw_sum;
   assign dut_sum2 = fault ? {1'b0, raw_sum2[1:0]} : raw_sum2;

   adder_resp_checker #(.WIDTH(2), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .vec_valid(vec_valid), .vec_ready(vec_ready),
      .vec_a(vec_a), .vec_b(vec_b), .dut_a(dut_a), .dut_b(dut_b), .dut_sum(dut_sum),
      .busy(busy), .pass_cnt(pass_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
      .first_err_a(fe_a), .first_err_b(fe_b), .first_err_sum(fe_sum)
   );

   adder_resp_checker #(.WIDTH(2), .SETTLE_CYCLES(SETTLE), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .vec_valid(vec_valid), .vec_ready(vec_ready2),
      .vec_a(vec_a), .vec_b(vec_b), .dut_a(dut_a2), .dut_b(dut_b2), .dut_sum(dut_sum2),
      .busy(busy2), .pass_cnt(pass_cnt2), .err_cnt(err_cnt2), .err_flag(err_flag2),
      .first_err_a(fe_a2), .first_err_b(fe_b2), .first_err_sum(fe_sum2)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction

   function automatic void model_clear();
      m_pass = 0; m_err = 0; m_flag = 0; m_fa = 0; m_fb = 0; m_fs = 0;
   endfunction

   function automatic void model_reset();
      model_clear();
      m_last_a = 0; m_last_b = 0;
   endfunction

   // Compare every observable output of both instances against the model (idle expected).
   task automatic check_all();
      check_eq("vec_ready", vec_ready, 1);
      check_eq("busy", busy, 0);
      check_eq("dut_a", dut_a, m_last_a);
      check_eq("dut_b", dut_b, m_last_b);
      check_eq("pass_cnt", pass_cnt, sat(m_pass, 65535));
      check_eq("err_cnt", err_cnt, sat(m_err, 65535));
      check_eq("err_flag", err_flag, m_flag);
      check_eq("first_err_a", fe_a, m_fa);
      check_eq("first_err_b", fe_b, m_fb);
      check_eq("first_err_sum", fe_sum, m_fs);
      check_eq("vec_ready2", vec_ready2, 1);
      check_eq("busy2", busy2, 0);
      check_eq("pass_cnt2", pass_cnt2, sat(m_pass, 3));
      check_eq("err_cnt2", err_cnt2, sat(m_err, 3));
      check_eq("err_flag2", err_flag2, m_flag);
      check_eq("first_err_sum2", fe_sum2, m_fs);
   endtask

   // Drive one vector and follow it to completion.
   // mode 0: normal; 1: clr asserted on the compare edge; 2: reset during settle.
   task automatic send_vec(input logic [1:0] a, input logic [1:0] b, input int mode);
      int waited;
      int s;
      @(negedge clk);
      vec_valid = 1'b1; vec_a = a; vec_b = b;
      waited = 0;
      while (!vec_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!vec_ready) begin
         check_eq("accept_timeout", 0, 1);
         vec_valid = 1'b0;
         return;
      end
      @(negedge clk);
      vec_valid = 1'b0;
      vec_a = 2'($urandom_range(0, 3));
      vec_b = 2'($urandom_range(0, 3));
      m_last_a = a; m_last_b = b;
      check_eq("accept_dut_a", dut_a, a);
      check_eq("accept_dut_b", dut_b, b);
      check_eq("accept_busy", busy, 1);
      check_eq("accept_ready", vec_ready, 0);
      if (mode == 2) begin
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         model_reset();
         check_all();
         return;
      end
      repeat (SETTLE) @(negedge clk);
      check_eq("check_busy", busy, 1);
      check_eq("check_ready", vec_ready, 0);
      check_eq("check_dut_a_held", dut_a, a);
      if (mode == 1) clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      s = int'(a) + int'(b);
      if (mode == 1) begin
         model_clear();
      end else if (fault && s >= 4) begin
         m_err++;
         if (!m_flag) begin
            m_flag = 1; m_fa = a; m_fb = b; m_fs = s % 4;
         end
      end else begin
         m_pass++;
      end
      check_all();
   endtask

   // Hold vec_valid high with new operands every cycle; only IDLE cycles accept.
   task automatic backpressure();
      int acc;
      logic [1:0] ea, eb, na, nb;
      acc = 0;
      ea = 2'(m_last_a); eb = 2'(m_last_b);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check_eq("bp_dut_a_stable", dut_a, ea);
         check_eq("bp_dut_b_stable", dut_b, eb);
         na = 2'($urandom_range(0, 3));
         nb = 2'($urandom_range(0, 3));
         vec_valid = 1'b1; vec_a = na; vec_b = nb;
         if (vec_ready) begin
            acc++; ea = na; eb = nb;
         end
      end
      @(negedge clk);
      vec_valid = 1'b0;
      check_eq("bp_accepted", acc, 3);
      m_last_a = ea; m_last_b = eb;
      m_pass += acc;
      repeat (SETTLE + 2) @(negedge clk);
      check_all();
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; vec_valid = 1'b0; vec_a = '0; vec_b = '0; fault = 1'b0;
      model_reset();

      // Reset held for two cycles.
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;
      @(negedge clk);
      check_all();

      // Exhaustive correct adder: 16 passes, 2-bit instance saturates at 3.
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            send_vec(2'(a), 2'(b), 0);
      check_eq("exh_pass16", pass_cnt, 16);
      check_eq("exh_pass_sat", pass_cnt2, 3);

      // Faulty adder: first error captured, second one leaves the capture alone.
      fault = 1'b1;
      send_vec(2'd3, 2'd1, 0);
      send_vec(2'd2, 2'd3, 0);
      check_eq("fault_err2", err_cnt, 2);
      check_eq("fault_first_sum", fe_sum, 0);
      fault = 1'b0;

      // Backpressure.
      backpressure();

      // Reset during settle aborts the vector.
      send_vec(2'd1, 2'd2, 2);
      send_vec(2'd1, 2'd1, 0);
      check_eq("after_abort_pass", pass_cnt, 1);

      // clr on the compare edge of a mismatch discards it.
      fault = 1'b1;
      send_vec(2'd3, 2'd3, 1);
      send_vec(2'd2, 2'd2, 0);

      // Randomized vectors with a random fault setting and occasional clr.
      for (int i = 0; i < 40; i++) begin
         fault = 1'($urandom_range(0, 1));
         send_vec(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0) ? 1 : 0);
         if ($urandom_range(0, 9) == 0) begin
            @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            model_clear();
            check_all();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
